// File: rtl/systolic_feeder.sv
// systolic_feeder: loads a weight tile and an activation tile from a host, then drives the
// west/north edge of an N x N systolic array: weight-load phase, skewed activation stream, drain, done.
// Ports: clk/reset (sync, active-high); wr_en/wr_sel/wr_addr/wr_data host buffer writes (IDLE only);
// start begins a sequence; busy/done status; load_weight/weight_out per-column weights;
// valid_out/a_out per-row activations; acc_in_out north accumulators (always zero).
module systolic_feeder #(
    parameter int N      = 2,
    parameter int M      = 4,
    parameter int DW     = 16,
    parameter int ACCW   = 32,
    parameter int ADDR_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic                wr_sel,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DW-1:0]       wr_data,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                load_weight,
    output logic [N*DW-1:0]     weight_out,
    output logic [N-1:0]        valid_out,
    output logic [N*DW-1:0]     a_out,
    output logic [N*ACCW-1:0]   acc_in_out
);
    localparam int MAXC = (M + N - 1 > 2 * N - 1) ? M + N - 1 : 2 * N - 1;
    localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [DW-1:0]   wbuf [N*N];
    logic [DW-1:0]   w_nx [N*N];
    logic [DW-1:0]   abuf [M*N];
    logic [DW-1:0]   a_nx [M*N];
    logic [N*DW-1:0] weight_n, a_n;
    logic [N-1:0]    valid_n;
    assign acc_in_out = '0;
    // Next buffer contents; out-of-range addresses match no entry and are dropped.
    // Weight reads use w_nx so a write coinciding with start is seen by the first LOAD_W cycle.
    always_comb begin
        w_nx = wbuf;
        a_nx = abuf;
        for (int j = 0; j < N * N; j++)
            if (wr_en && state == IDLE && !wr_sel && wr_addr == ADDR_W'(j)) w_nx[j] = wr_data;
        for (int j = 0; j < M * N; j++)
            if (wr_en && state == IDLE && wr_sel && wr_addr == ADDR_W'(j)) a_nx[j] = wr_data;
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (start) state_n = LOAD_W;
            end
            LOAD_W: if (cnt == CW'(N - 1)) begin
                state_n = STREAM;
                cnt_n   = '0;
            end
            STREAM: if (cnt == CW'(M + N - 2)) begin
                state_n = DRAIN;
                cnt_n   = '0;
            end
            DRAIN: if (cnt == CW'(2 * N - 2)) begin
                state_n = DONE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end
    // Outputs are precomputed from the next state/count so they are registered yet phase-aligned.
    // LOAD_W step k presents row N-1-k; STREAM step t presents A[t-i][i] on lane i.
    always_comb begin
        weight_n = '0;
        a_n      = '0;
        valid_n  = '0;
        for (int c = 0; c < N; c++)
            for (int r = 0; r < N; r++)
                if (state_n == LOAD_W && cnt_n == CW'(N - 1 - r)) weight_n[c*DW +: DW] = w_nx[r*N + c];
        for (int i = 0; i < N; i++)
            for (int m = 0; m < M; m++)
                if (state_n == STREAM && cnt_n == CW'(m + i)) begin
                    valid_n[i]        = 1'b1;
                    a_n[i*DW +: DW]   = abuf[m*N + i];
                end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            load_weight <= 1'b0;
            weight_out  <= '0;
            valid_out   <= '0;
            a_out       <= '0;
            for (int j = 0; j < N * N; j++) wbuf[j] <= '0;
            for (int j = 0; j < M * N; j++) abuf[j] <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            busy        <= state_n == LOAD_W || state_n == STREAM || state_n == DRAIN;
            done        <= state_n == DONE;
            load_weight <= state_n == LOAD_W;
            weight_out  <= weight_n;
            valid_out   <= valid_n;
            a_out       <= a_n;
            wbuf        <= w_nx;
            abuf        <= a_nx;
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed, table-driven bench for systolic_feeder (N=2, M=4).
module tb_systolic_feeder;
    logic        clk = 0, reset = 1, wr_en = 0, wr_sel = 0, start = 0;
    logic [2:0]  wr_addr = 0;
    logic [15:0] wr_data = 0;
    logic        busy, done, load_weight;
    logic [31:0] weight_out, a_out;
    logic [1:0]  valid_out;
    logic [63:0] acc_in_out;
    int          passed = 0, total = 0;
    systolic_feeder dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .done(done), .load_weight(load_weight),
        .weight_out(weight_out), .valid_out(valid_out), .a_out(a_out), .acc_in_out(acc_in_out)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        logic        busy, done, lw;
        logic [1:0]  v;
        logic [15:0] w0, w1, a0, a1;
    } row_t;
    row_t tbl [12];
    function automatic logic [132:0] pack(input row_t r);
        return {r.busy, r.done, r.lw, r.v, r.w1, r.w0, r.a1, r.a0, 64'h0};
    endfunction
    function automatic logic [132:0] got();
        return {busy, done, load_weight, valid_out, weight_out, a_out, acc_in_out};
    endfunction
    task automatic chk(input string name, input logic [132:0] act, input logic [132:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    task automatic wr(input logic sel, input logic [2:0] addr, input logic [15:0] data);
        wr_en = 1; wr_sel = sel; wr_addr = addr; wr_data = data;
        @(negedge clk);
        wr_en = 0;
    endtask
    // Loads W=[[1,2],[3,4]] and A; W[1][0] is written together with start.
    task automatic load_and_start();
        wr(0, 0, 1); wr(0, 1, 2); wr(0, 3, 4);
        for (int j = 0; j < 8; j++) wr(1, 3'(j), 16'(j + 1));
        wr_en = 1; wr_sel = 0; wr_addr = 2; wr_data = 3; start = 1;
    endtask
    // mode 0: plain; 1: inject ignored writes/starts while busy; 2: start held high (two runs)
    task automatic run_table(input int mode, input string tag);
        int n = (mode == 2) ? 24 : 12;
        for (int r = 0; r < n; r++) begin
            @(negedge clk);
            chk($sformatf("%s row%0d", tag, r), got(), pack(tbl[r % 12]));
            wr_en = 0;
            start = (mode == 2) ? (r < 22) : 1'b0;
            if (mode == 1) begin
                start = (r == 0 || r == 8);
                if (r == 3) begin
                    wr_en = 1; wr_sel = 1; wr_addr = 0; wr_data = 99;
                end
            end
        end
        start = 0; wr_en = 0;
    endtask
    initial begin
        int busy_cnt, done_at;
        logic nz;
        tbl[0]  = '{1, 0, 1, 2'b00, 3, 4, 0, 0};
        tbl[1]  = '{1, 0, 1, 2'b00, 1, 2, 0, 0};
        tbl[2]  = '{1, 0, 0, 2'b01, 0, 0, 1, 0};
        tbl[3]  = '{1, 0, 0, 2'b11, 0, 0, 3, 2};
        tbl[4]  = '{1, 0, 0, 2'b11, 0, 0, 5, 4};
        tbl[5]  = '{1, 0, 0, 2'b11, 0, 0, 7, 6};
        tbl[6]  = '{1, 0, 0, 2'b10, 0, 0, 0, 8};
        tbl[7]  = '{1, 0, 0, 2'b00, 0, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 2'b00, 0, 0, 0, 0};
        tbl[9]  = '{1, 0, 0, 2'b00, 0, 0, 0, 0};
        tbl[10] = '{0, 1, 0, 2'b00, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 2'b00, 0, 0, 0, 0};
        repeat (2) @(negedge clk);
        chk("reset outputs", got(), '0);
        reset = 0;
        @(negedge clk);
        chk("idle outputs", got(), '0);
        // Empty buffers: full-length run with zero data.
        start = 1;
        busy_cnt = 0; done_at = 0; nz = 0;
        for (int i = 1; i <= 20 && done_at == 0; i++) begin
            @(negedge clk);
            start = 0;
            if (busy) busy_cnt++;
            if (done) done_at = i;
            if (weight_out != 0 || a_out != 0) nz = 1;
        end
        chk("empty busy cycles", 133'(busy_cnt), 133'(10));
        chk("empty done cycle", 133'(done_at), 133'(11));
        chk("empty data zero", 133'(nz), 133'(0));
        @(negedge clk);
        load_and_start();
        run_table(0, "nominal");
        wr(0, 5, 77);
        start = 1;
        run_table(1, "inject");
        start = 1;
        run_table(0, "after-ignored");
        start = 1;
        run_table(2, "b2b");
        // Reset at STREAM t=2, then a clean rerun.
        start = 1;
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            start = 0;
        end
        chk("pre-reset stream t2", got(), pack(tbl[4]));
        reset = 1;
        @(negedge clk);
        chk("mid reset outputs", got(), '0);
        reset = 0;
        @(negedge clk);
        chk("post reset idle", got(), '0);
        load_and_start();
        run_table(0, "rerun");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Drives the west/north edge of an N x N systolic array built from processing_element instances.
- A host loads a weight tile and an activation tile into local register buffers. On start, the block:
  - sequences the weight-load phase (load_weight/weight);
  - streams skewed activations (valid/a_in, with acc_in held at zero);
  - waits for the array to drain, then signals done.
- It is the producer side of the PE input interface: it generates the stimulus the PE consumes.

Parameters:
- N, 2, array dimension: rows, columns, and activation vector length.
- M, 4, number of activation vectors per tile.
- DW, 16, activation/weight width.
- ACCW, 32, accumulator width.
- ADDR_W, 3, host write address width; must satisfy 2^ADDR_W >= M*N.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  host buffer write strobe.
- wr_sel  in  1  0 = weight buffer, 1 = activation buffer.
- wr_addr  in  ADDR_W  weight: r*N+c; activation: m*N+k.
- wr_data  in  DW  write data.
- start  in  1  begin sequence; sampled only in IDLE.
- busy  out  1  high while in LOAD_W, STREAM or DRAIN.
- done  out  1  one-cycle completion pulse.
- load_weight  out  1  to PE load_weight.
- weight_out  out  N*DW  per-column weight; column c at [c*DW +: DW].
- valid_out  out  N  per-row valid; row lane i at bit i.
- a_out  out  N*DW  per-row activation; lane i at [i*DW +: DW].
- acc_in_out  out  N*ACCW  north accumulator inputs; constant 0.

Behaviour:
- All outputs are registered.
- Synchronous reset, regardless of state:
  - state returns to IDLE;
  - all outputs go to 0;
  - both buffers are cleared to 0;
  - all counters are cleared.
- Buffer writes:
  - Accepted only when wr_en=1 and state=IDLE; writes in any other state are ignored.
  - Weight writes with wr_addr >= N*N are ignored.
  - Activation writes with wr_addr >= M*N are ignored.
  - A write and start in the same IDLE cycle: the write lands and the sequence uses the new value.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - outputs 0;
  - start=1 at edge E moves to LOAD_W, with busy=1 from the cycle after E.
- LOAD_W, N cycles, k = 0..N-1:
  - load_weight=1;
  - weight_out column c = W[N-1-k][c], so the bottom row enters first and row r settles in PE row r after shifting via w_out;
  - valid_out=0 and a_out=0.
- STREAM, M+N-1 cycles, t = 0..M+N-2:
  - load_weight=0;
  - lane i: if 0 <= t-i < M then valid_out[i]=1 and a_out lane i = A[t-i][i];
  - otherwise valid_out[i]=0 and the lane is 0.
- DRAIN, 2N-1 cycles:
  - all outputs 0;
  - busy stays 1.
- DONE, 1 cycle:
  - done=1, busy=0;
  - then IDLE.
- start while not in IDLE is ignored; start held high across DONE→IDLE starts a new sequence from IDLE.
- Total cycles from the first busy cycle to done: N + (M+N-1) + (2N-1).
- acc_in_out is always 0.
- Counter width is sized for max(N, M+N-1, 2N-1); there is no wrap within a phase.

Test Plan:
- Reset and idle: hold reset 2 cycles → all outputs 0, busy=0, done=0. Pulse start with empty buffers → full sequence runs with all a_out and weight_out 0; done after 2+5+3 = 10 busy cycles.
- Nominal run (N=2, M=4):
  - stimulus: W = [[1,2],[3,4]]; A = [1,2],[3,4],[5,6],[7,8]; then start;
  - LOAD_W: weight_out = {c0=3, c1=4}, then {c0=1, c1=2}, with load_weight=1 for both cycles;
  - STREAM lane0: a = 1,3,5,7,0 with valid 1,1,1,1,0;
  - STREAM lane1: a = 0,2,4,6,8 with valid 0,1,1,1,1;
  - DRAIN: 3 zero cycles, then a single done pulse.
- Writes while busy: write wr_sel=1, wr_addr=0, wr_data=99 during STREAM → ignored; a second run still streams lane0 first value 1. Out-of-range weight write (wr_addr=5) → buffer unchanged.
- Start while busy: start pulses during LOAD_W and DRAIN → no restart; done occurs exactly once at the nominal cycle.
- Reset mid-operation: assert reset at STREAM t=2 → next cycle all outputs 0 and busy=0. A new start after rewriting the buffers runs a clean, full-length sequence.
- Back-to-back: start held high continuously → second sequence begins one cycle after the IDLE cycle that follows DONE; outputs match the nominal run.
